// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//   Drains DATA_WIDTH-bit entries from a byte FIFO (rd_en / data_out / valid
//   with one-cycle read latency) and packs LANES consecutive entries into one
//   wide word. Lane 0 is the first entry read and sits in the LSBs. Words are
//   offered downstream on a valid/ready handshake. A flush request emits a
//   partial word; unused lanes read as zero.
//
//   Optional feature macro: PACKER_TIMEOUT_FLUSH_EN
//     When defined, a partial word that sees FLUSH_TIMEOUT idle cycles in FILL
//     is flushed automatically, exactly as if the flush port had been pulsed.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   fifo_empty    in   FIFO empty flag
//   fifo_valid    in   FIFO read data valid (one cycle after accepted rd_en)
//   fifo_data_out in   FIFO read data
//   fifo_rd_en    out  read request to FIFO (combinational)
//   flush         in   emit the current partial word
//   word_out      out  packed word
//   word_lanes    out  number of populated lanes in word_out
//   word_valid    out  word_out / word_lanes valid
//   word_ready    in   downstream accepts word
//   pack_count    out  number of words handed off, wraps at 2^32
//   proto_err     out  sticky: fifo_valid seen with no read in flight
// -----------------------------------------------------------------------------
module fifo_word_packer #(
   parameter int DATA_WIDTH    = 8,
   parameter int LANES         = 4,
   parameter int FLUSH_TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fifo_empty,
   input  logic                          fifo_valid,
   input  logic [DATA_WIDTH-1:0]         fifo_data_out,
   output logic                          fifo_rd_en,
   input  logic                          flush,
   output logic [DATA_WIDTH*LANES-1:0]   word_out,
   output logic [$clog2(LANES+1)-1:0]    word_lanes,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [31:0]                   pack_count,
   output logic                          proto_err
);

   localparam int PW = $clog2(LANES+1);
   localparam int WW = DATA_WIDTH*LANES;
   localparam logic [PW:0] LANES_X = (PW+1)'(LANES);

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   if (FLUSH_TIMEOUT < 1) begin : g_timeout_range
      $error("fifo_word_packer: FLUSH_TIMEOUT must be at least 1");
   end

   state_t          state_r, state_n_s;
   logic [PW-1:0]   lane_ptr_r, lane_ptr_n_s;
   logic            inflight_r, inflight_n_s;
   logic            flush_pend_r, flush_pend_n_s;
   logic            post_rst_r;
   logic [WW-1:0]   word_r, word_n_s;
   logic [PW-1:0]   word_lanes_r, word_lanes_n_s;
   logic            word_valid_r, word_valid_n_s;
   logic [31:0]     pack_count_r, pack_count_n_s;
   logic            proto_err_r, proto_err_n_s;

   logic            fill_s;
   logic [PW:0]     ptr_sum_s;
   logic [PW-1:0]   new_ptr_s;
   logic            rd_en_s;
   logic            tmo_s;

`ifdef PACKER_TIMEOUT_FLUSH_EN
   localparam int CW = $clog2(FLUSH_TIMEOUT+1);
   localparam logic [CW-1:0] TMO_LAST = CW'(FLUSH_TIMEOUT-1);

   logic [CW-1:0]   idle_cnt_r, idle_cnt_n_s;
   logic            idle_s;

   // Idle counter: partial word waiting with nothing in flight; fires on the last idle cycle.
   always_comb begin
      idle_s = (state_r == FILL) && (lane_ptr_r != {PW{1'b0}}) && !inflight_r && !fifo_valid;
      tmo_s  = idle_s && (idle_cnt_r == TMO_LAST);
      if ((state_r != FILL) || fifo_valid) begin
         idle_cnt_n_s = {CW{1'b0}};
      end else if (idle_s && (idle_cnt_r != TMO_LAST)) begin
         idle_cnt_n_s = idle_cnt_r + CW'(1);
      end else begin
         idle_cnt_n_s = idle_cnt_r;
      end
   end

   // Idle counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_r <= {CW{1'b0}};
      end else begin
         idle_cnt_r <= idle_cnt_n_s;
      end
   end
`else
   assign tmo_s = 1'b0;
`endif

   // Read issue and lane landing. A read is allowed only while the landed plus
   // outstanding lanes still leave room, so at most one read is ever in flight.
   always_comb begin
      fill_s    = fifo_valid && inflight_r;
      ptr_sum_s = {1'b0, lane_ptr_r} + (PW+1)'(inflight_r);
      new_ptr_s = lane_ptr_r + PW'(fill_s);
      rd_en_s   = (state_r == FILL) && !fifo_empty && !flush_pend_r && (ptr_sum_s < LANES_X);
   end

   assign fifo_rd_en = rd_en_s;

   // Next-state and datapath for FILL/HOLD.
   always_comb begin
      state_n_s      = state_r;
      lane_ptr_n_s   = lane_ptr_r;
      flush_pend_n_s = flush_pend_r;
      word_n_s       = word_r;
      word_lanes_n_s = word_lanes_r;
      word_valid_n_s = word_valid_r;
      pack_count_n_s = pack_count_r;
      inflight_n_s   = rd_en_s;
      // Data arriving with no read outstanding is dropped; the cycle right after
      // reset is exempt because a read issued before reset may still land.
      proto_err_n_s  = proto_err_r | (fifo_valid && !inflight_r && !post_rst_r);

      case (state_r)
         FILL: begin
            for (int i = 0; i < LANES; i++) begin
               word_n_s[i*DATA_WIDTH +: DATA_WIDTH] =
                  (fill_s && (lane_ptr_r == PW'(i))) ? fifo_data_out
                                                     : word_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
            lane_ptr_n_s = new_ptr_s;
            if (new_ptr_s == PW'(LANES)) begin
               // A full word wins over any simultaneous flush.
               state_n_s      = HOLD;
               word_valid_n_s = 1'b1;
               word_lanes_n_s = new_ptr_s;
               flush_pend_n_s = 1'b0;
            end else if (flush || tmo_s || flush_pend_r) begin
               if (rd_en_s || (inflight_r && !fifo_valid)) begin
                  // Wait for the outstanding lane before closing the word.
                  flush_pend_n_s = 1'b1;
               end else if (new_ptr_s != {PW{1'b0}}) begin
                  state_n_s      = HOLD;
                  word_valid_n_s = 1'b1;
                  word_lanes_n_s = new_ptr_s;
                  flush_pend_n_s = 1'b0;
               end else begin
                  flush_pend_n_s = 1'b0;
               end
            end else begin
               flush_pend_n_s = flush_pend_r;
            end
         end
         HOLD: begin
            if (word_valid_r && word_ready) begin
               state_n_s      = FILL;
               pack_count_n_s = pack_count_r + 32'd1;
               word_n_s       = {WW{1'b0}};
               word_lanes_n_s = {PW{1'b0}};
               word_valid_n_s = 1'b0;
               lane_ptr_n_s   = {PW{1'b0}};
               flush_pend_n_s = 1'b0;
            end else begin
               state_n_s      = HOLD;
            end
         end
         default: begin
            state_n_s = FILL;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= FILL;
         lane_ptr_r   <= {PW{1'b0}};
         inflight_r   <= 1'b0;
         flush_pend_r <= 1'b0;
         post_rst_r   <= 1'b1;
         word_r       <= {WW{1'b0}};
         word_lanes_r <= {PW{1'b0}};
         word_valid_r <= 1'b0;
         pack_count_r <= 32'd0;
         proto_err_r  <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         lane_ptr_r   <= lane_ptr_n_s;
         inflight_r   <= inflight_n_s;
         flush_pend_r <= flush_pend_n_s;
         post_rst_r   <= 1'b0;
         word_r       <= word_n_s;
         word_lanes_r <= word_lanes_n_s;
         word_valid_r <= word_valid_n_s;
         pack_count_r <= pack_count_n_s;
         proto_err_r  <= proto_err_n_s;
      end
   end

   assign word_out   = word_r;
   assign word_lanes = word_lanes_r;
   assign word_valid = word_valid_r;
   assign pack_count = pack_count_r;
   assign proto_err  = proto_err_r;

endmodule
